// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the SRAM arbiter and its access sequencer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

    localparam int ADDR_W_DEF   = 18;
    localparam int WAIT_CYC_DEF = 1;

endpackage

// File: rtl/sram_seq.sv
// SRAM access sequencer: one SETUP / STROBE / HOLD pass per start, controls registered from next state.
// state  | meaning
// IDLE   | no access, all SRAM controls inactive
// SETUP  | ce_n low, address (and write data) driven
// STROBE | oe_n or we_n low for WAIT_CYC cycles
// HOLD   | strobe released, address/data held; may chain straight into SETUP
module sram_seq
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              write_i,
    input  logic [15:0]       addr_i,
    input  logic [15:0]       wdata_i,
    output logic              accept_o,
    output logic              hold_o,
    output logic              capture_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [15:0]       sram_dout_o,
    output logic              sram_data_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYC - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              data_oe_q, data_oe_d;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            data_oe_q <= data_oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start_i) begin
                    state_d = ST_SETUP;
                    wr_d    = write_i;
                    addr_d  = ADDR_W'(addr_i);
                    if (write_i) wdata_d = wdata_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_LOAD;
            end
            ST_STROBE: begin
                if (cnt_q == 3'd0) state_d = ST_HOLD;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controls are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        ce_n_d    = (state_d == ST_IDLE);
        oe_n_d    = !((state_d == ST_STROBE) && !wr_d);
        we_n_d    = !((state_d == ST_STROBE) && wr_d);
        data_oe_d = wr_d && (state_d != ST_IDLE);
    end

    assign accept_o       = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign hold_o         = (state_q == ST_HOLD);
    assign capture_o      = (state_q == ST_STROBE) && (cnt_q == 3'd0) && !wr_q;
    assign sram_addr_o    = addr_q;
    assign sram_dout_o    = wdata_q;
    assign sram_data_oe_o = data_oe_q;
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM between IF and MEM: MEM-first grant, per-step done flags, rdata capture and stall.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_ready,
    output logic              stall_out,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dout,
    input  logic [15:0]       sram_din,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    owner_t      owner_q, owner_d;
    logic        mem_done_q, mem_done_d;
    logic        if_done_q, if_done_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic        accept, hold, capture;
    logic        mem_req, mem_busy, if_busy;
    logic        grant_mem, grant_if, start;

    assign mem_req   = mem_read | mem_write;
    assign mem_ready = hold & (owner_q == OWN_MEM);
    assign if_ready  = hold & (owner_q == OWN_IF);

    // A port finishing in HOLD counts as served, so it is not re-granted on the same edge.
    assign mem_busy  = mem_done_q | mem_ready;
    assign if_busy   = if_done_q | if_ready;
    assign grant_mem = accept & mem_req & ~mem_busy;
    assign grant_if  = accept & ~grant_mem & if_req & ~if_busy;
    assign start     = grant_mem | grant_if;
    assign stall_out = rst & ((mem_req & ~mem_busy) | (if_req & ~if_busy));

    always_comb begin
        owner_d     = owner_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if (start) owner_d = grant_mem ? OWN_MEM : OWN_IF;
        if (capture && (owner_q == OWN_IF))  if_rdata_d  = sram_din;
        if (capture && (owner_q == OWN_MEM)) mem_rdata_d = sram_din;
        // Clearing on pipeline advance wins over setting, or a fresh request would be skipped.
        mem_done_d = stall_out ? (mem_done_q | mem_ready) : 1'b0;
        if_done_d  = stall_out ? (if_done_q | if_ready) : 1'b0;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_IF;
            mem_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= 16'h0000;
            mem_rdata_q <= 16'h0000;
        end else begin
            owner_q     <= owner_d;
            mem_done_q  <= mem_done_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    sram_seq #(
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC)
    ) u_seq (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .write_i        (grant_mem & mem_write),
        .addr_i         (grant_mem ? mem_addr : if_addr),
        .wdata_i        (mem_wdata),
        .accept_o       (accept),
        .hold_o         (hold),
        .capture_o      (capture),
        .sram_addr_o    (sram_addr),
        .sram_dout_o    (sram_dout),
        .sram_data_oe_o (sram_data_oe),
        .sram_ce_n_o    (sram_ce_n),
        .sram_oe_n_o    (sram_oe_n),
        .sram_we_n_o    (sram_we_n)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: WAIT_CYC=1 instance with scoreboard and vector table, WAIT_CYC=3 instance for strobe length.
module tb_mem_arbiter;

    logic        clk, rst1, rst3;
    logic        if_req, mem_read, mem_write;
    logic [15:0] if_addr, mem_addr, mem_wdata, sram_din, din_fixed;
    logic        din_model;

    logic [15:0] if_rdata, mem_rdata, sram_dout;
    logic        if_ready, mem_ready, stall_out, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [17:0] sram_addr;

    logic [15:0] d3_if_rdata, d3_mem_rdata, d3_sram_dout;
    logic        d3_if_ready, d3_mem_ready, d3_stall_out, d3_sram_data_oe, d3_sram_ce_n, d3_sram_oe_n, d3_sram_we_n;
    logic [17:0] d3_sram_addr;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        is_mem;
        logic [15:0] rdata;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        mrd;
        logic        mwr;
        logic        ifr;
        logic [15:0] maddr;
        logic [15:0] iaddr;
        logic [15:0] wdata;
        int          exp_rd;
        int          exp_wr;
    } vec_t;
    vec_t vec[0:7];

    logic        we_s[0:15], oe_s[0:15], ce_s[0:15], doe_s[0:15], st_s[0:15], ifr_s[0:15], mr_s[0:15];
    logic [17:0] ad_s[0:15];
    logic [15:0] do_s[0:15], rd_s[0:15];
    logic [15:0] exp_mem;

    function automatic logic [15:0] sram_model(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    assign sram_din = din_model ? sram_model(sram_addr[15:0]) : din_fixed;

    initial clk = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(18), .WAIT_CYC(1)) dut1 (
        .clk(clk), .rst(rst1),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_out(stall_out),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din), .sram_data_oe(sram_data_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mem_arbiter #(.ADDR_W(18), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst3),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(d3_if_rdata), .if_ready(d3_if_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(d3_mem_rdata), .mem_ready(d3_mem_ready), .stall_out(d3_stall_out),
        .sram_addr(d3_sram_addr), .sram_dout(d3_sram_dout), .sram_din(sram_din), .sram_data_oe(d3_sram_data_oe),
        .sram_ce_n(d3_sram_ce_n), .sram_oe_n(d3_sram_oe_n), .sram_we_n(d3_sram_we_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic is_mem, input logic [15:0] rd);
        sb_t e;
        e.is_mem = is_mem;
        e.rdata  = rd;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic is_mem, input logic [15:0] rd);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: ready from port %0d with nothing expected", is_mem);
        end else begin
            e = sb_q.pop_front();
            chk("sb_port", 32'(is_mem), 32'(e.is_mem));
            chk("sb_rdata", 32'(rd), 32'(e.rdata));
        end
    endtask

    always @(posedge clk) begin
        if (rst1 === 1'b1) begin
            if (mem_ready === 1'b1) sb_pop(1'b1, mem_rdata);
            if (if_ready === 1'b1)  sb_pop(1'b0, if_rdata);
        end
    end

    task automatic sample1(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            we_s[c] = sram_we_n;  oe_s[c] = sram_oe_n;  ce_s[c] = sram_ce_n;
            doe_s[c] = sram_data_oe; st_s[c] = stall_out; ifr_s[c] = if_ready;
            mr_s[c] = mem_ready;  ad_s[c] = sram_addr;  do_s[c] = sram_dout;
            rd_s[c] = if_rdata;
        end
    endtask

    task automatic sample3(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            we_s[c] = d3_sram_we_n; oe_s[c] = d3_sram_oe_n; ce_s[c] = d3_sram_ce_n;
            doe_s[c] = d3_sram_data_oe; st_s[c] = d3_stall_out; ifr_s[c] = d3_if_ready;
            mr_s[c] = d3_mem_ready; ad_s[c] = d3_sram_addr; do_s[c] = d3_sram_dout;
            rd_s[c] = d3_mem_rdata;
        end
    endtask

    task automatic clear_req();
        if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        int  nwr, nrd, steps, nready;
        logic done;
        logic [17:0] waddr;
        logic [15:0] wdat;
        vec_t v;

        vec[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1, 0};
        vec[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h0000, 1, 0};
        vec[2] = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1111, 0, 1};
        vec[3] = '{1'b1, 1'b0, 1'b1, 16'h0044, 16'h0055, 16'h0000, 2, 0};
        vec[4] = '{1'b0, 1'b1, 1'b1, 16'h0066, 16'h0077, 16'h2222, 1, 1};
        vec[5] = '{1'b1, 1'b1, 1'b0, 16'h0088, 16'h0000, 16'h3333, 0, 1};
        vec[6] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'h0000, 2, 0};
        vec[7] = '{1'b0, 1'b1, 1'b1, 16'h8001, 16'h0000, 16'h4444, 1, 1};

        // Reset state, with requests pending to show stall is held low.
        rst1 = 1'b0; rst3 = 1'b0; din_model = 1'b0; din_fixed = 16'h0000;
        if_req = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        if_addr = 16'h0000; mem_addr = 16'h0000; mem_wdata = 16'h0000;
        exp_mem = 16'h0000;
        #12;
        chk("rst_stall", 32'(stall_out), 0);
        chk("rst_ce_n", 32'(sram_ce_n), 1);
        chk("rst_oe_n", 32'(sram_oe_n), 1);
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_data_oe", 32'(sram_data_oe), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dout", 32'(sram_dout), 0);
        chk("rst_rdata", 32'({if_rdata, mem_rdata}), 0);
        chk("rst_ready", 32'({if_ready, mem_ready}), 0);
        chk("rst_d3_stall", 32'(d3_stall_out), 0);
        clear_req();

        // IF read, WAIT_CYC=1.
        @(negedge clk); #1;
        rst1 = 1'b1; if_req = 1'b1; if_addr = 16'h0040; din_fixed = 16'h1234;
        sb_push(1'b0, 16'h1234);
        sample1(4);
        @(negedge clk); #1; clear_req();
        for (int c = 0; c < 4; c++) chk($sformatf("t1_oe_n_c%0d", c), 32'(oe_s[c]), (c == 2) ? 0 : 1);
        chk("t1_stall_c0", 32'(st_s[0]), 1);
        chk("t1_addr_c1", 32'(ad_s[1]), 'h40);
        chk("t1_ce_n_c1", 32'(ce_s[1]), 0);
        chk("t1_if_ready_c3", 32'(ifr_s[3]), 1);
        chk("t1_if_rdata_c3", 32'(rd_s[3]), 'h1234);
        chk("t1_stall_c3", 32'(st_s[3]), 0);

        // Simultaneous MEM write and IF fetch: write first, then fetch, no repeat.
        @(negedge clk); #1; rst1 = 1'b0; exp_mem = 16'h0000;
        @(negedge clk); #1;
        rst1 = 1'b1; mem_write = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'hBEEF;
        if_req = 1'b1; if_addr = 16'h0041; din_fixed = 16'h5555;
        sb_push(1'b1, exp_mem);
        sb_push(1'b0, 16'h5555);
        sample1(7);
        @(negedge clk); #1; clear_req();
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("t2_we_n_c%0d", c), 32'(we_s[c]), (c == 2) ? 0 : 1);
            chk($sformatf("t2_data_oe_c%0d", c), 32'(doe_s[c]), (c >= 1 && c <= 3) ? 1 : 0);
            chk($sformatf("t2_stall_c%0d", c), 32'(st_s[c]), (c <= 5) ? 1 : 0);
        end
        chk("t2_addr_c1", 32'(ad_s[1]), 'h08000);
        chk("t2_dout_c1", 32'(do_s[1]), 'hBEEF);
        chk("t2_mem_ready_c3", 32'(mr_s[3]), 1);
        chk("t2_ce_n_c4", 32'(ce_s[4]), 0);
        chk("t2_addr_c4", 32'(ad_s[4]), 'h00041);
        chk("t2_if_ready_c6", 32'(ifr_s[6]), 1);
        nwr = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            if (!sram_we_n) nwr++;
        end
        chk("t2_no_second_write", 32'(nwr), 0);

        // Vector table, one pipeline step each, SRAM data from the address model.
        din_model = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = vec[i];
            @(negedge clk); #1;
            mem_read = v.mrd; mem_write = v.mwr; mem_addr = v.maddr; mem_wdata = v.wdata;
            if_req = v.ifr; if_addr = v.iaddr;
            if (v.mrd || v.mwr) begin
                if (!v.mwr) exp_mem = sram_model(v.maddr);
                sb_push(1'b1, exp_mem);
            end
            if (v.ifr) sb_push(1'b0, sram_model(v.iaddr));
            nwr = 0; nrd = 0; done = 1'b0; waddr = '0; wdat = '0;
            for (int c = 0; c < 30 && !done; c++) begin
                @(posedge clk);
                if (!sram_we_n) begin nwr++; waddr = sram_addr; wdat = sram_dout; end
                if (!sram_oe_n) nrd++;
                if (!stall_out) done = 1'b1;
            end
            @(negedge clk); #1; clear_req();
            chk($sformatf("vec%0d_step_done", i), 32'(done), 1);
            chk($sformatf("vec%0d_reads", i), 32'(nrd), 32'(v.exp_rd));
            chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(v.exp_wr));
            if (v.exp_wr > 0) begin
                chk($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(v.maddr));
                chk($sformatf("vec%0d_wdata", i), 32'(wdat), 32'(v.wdata));
            end
        end

        // MEM read held over three pipeline steps: exactly one read per step.
        @(negedge clk); #1;
        din_model = 1'b0; din_fixed = 16'h00AA; mem_read = 1'b1; mem_addr = 16'h0100;
        for (int k = 0; k < 3; k++) sb_push(1'b1, 16'h00AA);
        exp_mem = 16'h00AA;
        steps = 0; nrd = 0; nready = 0;
        for (int c = 0; c < 60 && steps < 3; c++) begin
            @(posedge clk);
            if (!sram_oe_n) nrd++;
            if (mem_ready) nready++;
            if (!stall_out) steps++;
        end
        @(negedge clk); #1; clear_req();
        chk("t3_steps", 32'(steps), 3);
        chk("t3_reads", 32'(nrd), 3);
        chk("t3_ready_pulses", 32'(nready), 3);
        chk("t3_mem_rdata", 32'(mem_rdata), 'h00AA);

        // Reset during the STROBE of a write, then a clean read.
        @(negedge clk); #1;
        mem_write = 1'b1; mem_addr = 16'h1234; mem_wdata = 16'hCAFE;
        repeat (3) @(posedge clk);
        chk("t4_in_strobe", 32'(sram_we_n), 0);
        #2; rst1 = 1'b0; #1;
        chk("t4_ce_n", 32'(sram_ce_n), 1);
        chk("t4_oe_n", 32'(sram_oe_n), 1);
        chk("t4_we_n", 32'(sram_we_n), 1);
        chk("t4_data_oe", 32'(sram_data_oe), 0);
        chk("t4_addr", 32'(sram_addr), 0);
        chk("t4_dout", 32'(sram_dout), 0);
        chk("t4_stall", 32'(stall_out), 0);
        chk("t4_mem_rdata", 32'(mem_rdata), 0);
        sb_q.delete(1);
        @(negedge clk); #1;
        clear_req();
        rst1 = 1'b1; din_model = 1'b1; mem_read = 1'b1; mem_addr = 16'h0200;
        exp_mem = sram_model(16'h0200);
        sb_push(1'b1, exp_mem);
        sample1(4);
        @(negedge clk); #1; clear_req();
        chk("t4_ce_n_c0", 32'(ce_s[0]), 1);
        chk("t4_ce_n_c1", 32'(ce_s[1]), 0);
        chk("t4_oe_n_c2", 32'(oe_s[2]), 0);
        chk("t4_mem_ready_c3", 32'(mr_s[3]), 1);
        chk("t4_mem_rdata_after", 32'(mem_rdata), 32'(sram_model(16'h0200)));

        // WAIT_CYC=3 read of 0x0002 on the second instance.
        @(negedge clk); #1; rst1 = 1'b0;
        @(negedge clk); #1;
        rst3 = 1'b1; din_model = 1'b0; din_fixed = 16'h7E57; mem_read = 1'b1; mem_addr = 16'h0002;
        sample3(7);
        @(negedge clk); #1; clear_req();
        nrd = 0;
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("t5_oe_n_c%0d", c), 32'(oe_s[c]), (c >= 2 && c <= 4) ? 0 : 1);
            if (!oe_s[c]) nrd++;
        end
        chk("t5_oe_cycles", 32'(nrd), 3);
        chk("t5_addr_c1", 32'(ad_s[1]), 'h00002);
        chk("t5_ready_c4", 32'(mr_s[4]), 0);
        chk("t5_ready_c5", 32'(mr_s[5]), 1);
        chk("t5_rdata_c5", 32'(rd_s[5]), 'h7E57);
        chk("t5_stall_c4", 32'(st_s[4]), 1);
        chk("t5_stall_c5", 32'(st_s[5]), 0);

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external SRAM between instruction fetch (IF) and the MEM stage of the 16-bit pipeline. It turns the `memread`/`memwrite` strobes registered by the EX/MEM pipeline register, and the IF fetch request, into glitch-free SRAM `ce_n`/`oe_n`/`we_n` sequences. It stalls the pipeline until every pending access of the current pipeline step has completed. MEM has priority; each request is served exactly once per pipeline advance.

## Interface
Parameters:
- `ADDR_W`, 18: SRAM address width; 16-bit logical addresses are zero-extended.
- `WAIT_CYC`, 1: number of STROBE cycles per access; legal range 1..7.

Ports:
- `clk` input, 1: system clock; all state updates on the falling edge, matching the pipeline registers.
- `rst` input, 1: asynchronous, active-low reset.
- `if_req` input, 1: fetch request.
- `if_addr` input, 16: fetch address.
- `if_rdata` output, 16: fetched word.
- `if_ready` output, 1: fetch complete; 1-cycle pulse.
- `mem_read` input, 1: load request, from EX/MEM `memread_out`.
- `mem_write` input, 1: store request, from EX/MEM `memwrite_out`.
- `mem_addr` input, 16: from EX/MEM `alu_out`.
- `mem_wdata` input, 16: from EX/MEM `wdata_out`.
- `mem_rdata` output, 16: loaded word.
- `mem_ready` output, 1: MEM access complete; 1-cycle pulse.
- `stall_out` output, 1: freeze PC and all pipeline registers.
- `sram_addr` output, ADDR_W: SRAM address.
- `sram_dout` output, 16: write data.
- `sram_din` input, 16: read data.
- `sram_data_oe` output, 1: top-level tristate enable for `sram_dout`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` output, 1 each: SRAM controls, active-low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- Grant in IDLE or HOLD, evaluated in this order:
  - MEM, if (`mem_read` or `mem_write`) and not `mem_done`.
  - Otherwise IF, if `if_req` and not `if_done`.
  - Otherwise no grant.
- A grant latches the owner, address, write flag and write data, then moves to SETUP. With no grant, the FSM goes to (or stays in) IDLE.
- `mem_read` and `mem_write` both high: treated as a write.
- SETUP, 1 cycle:
  - `ce_n`=0, `sram_addr` valid.
  - For a write, `sram_data_oe`=1 and `sram_dout` valid.
- STROBE, `WAIT_CYC` cycles, counted by a 3-bit counter:
  - Read: `oe_n`=0.
  - Write: `we_n`=0.
  - Read data: `sram_din` is captured into the owner's rdata register on the edge that leaves the last STROBE cycle.
- HOLD, 1 cycle:
  - `oe_n`=`we_n`=1, `ce_n`=0, address held.
  - For a write, `sram_data_oe` stays 1 as data hold time.
  - The owner's ready pulses.
  - The owner's done flag is set on the exit edge.
- Done flags (`mem_done`, `if_done`):
  - Both are cleared on any edge where `stall_out`=0, i.e. when the pipeline advances.
  - They prevent re-issue of a request that is held stable during a stall.
- `stall_out` (combinational) = (mem request and not (`mem_done` or `mem_ready`)) or (`if_req` and not (`if_done` or `if_ready`)).
- Rdata registers hold their value until the same port completes its next read; writes leave `mem_rdata` unchanged.

## Timing
- Request sampled in IDLE at edge 0:
  - SETUP in cycle 1.
  - STROBE in cycles 2..`WAIT_CYC`+1.
  - HOLD/ready in cycle `WAIT_CYC`+2.
- Back-to-back: HOLD goes directly to SETUP, so each further access takes `WAIT_CYC`+2 cycles with no idle gap.
- All SRAM controls are registered, decoded from the next state; no combinational glitches.
- `we_n` low for exactly `WAIT_CYC` cycles. Address and data are stable from one cycle before `we_n` falls to one cycle after it rises.
- Reset (asynchronous, any state, including mid-STROBE):
  - FSM to IDLE; done flags and counter cleared.
  - `ce_n`=`oe_n`=`we_n`=1, `sram_data_oe`=0.
  - `sram_addr`=0, `sram_dout`=0.
  - `if_rdata`=`mem_rdata`=0, ready outputs 0.
  - `stall_out` forced to 0 while `rst`=0.
- First grant after reset release: evaluated at the first falling edge with `rst`=1.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum.
  - Owner enum (OWN_IF, OWN_MEM).
  - `ADDR_W` and `WAIT_CYC` defaults.
- Optional sub-module `sram_seq`: SETUP/STROBE/HOLD sequencer plus wait counter.
  - Inputs: start, write, addr, wdata.
  - Outputs: SRAM pins, capture strobe, done.
  - `mem_arbiter` keeps the grant logic, done flags, rdata registers and stall.

## Test plan
- `WAIT_CYC`=1; `if_req`=1 with `if_addr`=0x0040 and `sram_din`=0x1234 → `oe_n` low in cycle 2 only. In cycle 3: `if_ready`=1, `if_rdata`=0x1234, `stall_out`=0.
- Simultaneous `mem_write` (addr 0x8000, data 0xBEEF) and IF fetch of 0x0041:
  - Write first: `we_n` low in cycle 2 only, `sram_data_oe` high in cycles 1–3.
  - Then the IF read: SETUP at cycle 4, `if_ready` in cycle 6.
  - `stall_out` high in cycles 0–5, 0 in cycle 6.
  - No second write occurs.
- `mem_read` of 0x0100 held high for 3 pipeline steps with `sram_din`=0x00AA → exactly one read per step, `mem_rdata`=0x00AA, `mem_done` prevents duplicates while stalled.
- `rst` asserted in STROBE of a write → all controls inactive and `sram_data_oe`=0 immediately. After release, the next request starts cleanly from IDLE.
- `WAIT_CYC`=3; read of 0x0002 → `oe_n` low for exactly 3 cycles, ready in cycle 5, `sram_addr`=0x00002.
- Both `mem_read` and `mem_write` high → treated as a write: `we_n` pulses, `oe_n` stays 1.
